seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
Multi-cycle, parametrised add/subtract unit built from a CHUNK-bit ripple slice of full-adder cells, reused once per cycle over WIDTH/CHUNK chunks, LSB chunk first.
Trades latency for area in the multiplier datapath, where it accumulates partial products.
Adds over the single-bit cell: operand width, carry registered between cycles, subtract mode, signed overflow flag, and valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits processed per cycle; 1 <= CHUNK <= WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand bundle valid.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
sub  input  1  0 = A+B+cin; 1 = A-B-cin, computed as A + ~B + ~cin.
out_valid  output  1  result valid; high only in DONE.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  carry out of the MSB; in subtract mode, 1 means no borrow.
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst=1): state=IDLE, chunk counter=0, sum=0, cout=0, overflow=0, out_valid=0, in_ready=1 once the state reaches IDLE.
- Define NCH = WIDTH/CHUNK and CW = clog2(NCH) with a minimum of 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On the edge with in_valid=1, latch a, b_eff = sub ? ~b : b, and carry register = cin ^ sub.
  - Clear the counter; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge adds chunk[idx] of a and b_eff plus the carry register through the slice.
  - Write the CHUNK-bit result into sum[idx*CHUNK +: CHUNK] and store the slice carry-out in the carry register.
  - Increment idx.
  - On the edge that processes idx=NCH-1:
    - cout = final carry.
    - overflow = slice carry into its MSB XOR final carry.
    - Go to DONE.
- Latency: out_valid rises exactly NCH cycles after the input handshake edge (NCH=1 gives 1 cycle).
- DONE:
  - out_valid=1; sum, cout and overflow stay stable.
  - On the edge with out_ready=1, go to IDLE; sum, cout and overflow keep their values.
  - out_ready=0 stalls the block indefinitely.
- Throughput: one operation per NCH+2 cycles minimum. There is no accept in DONE and no overlap.
- in_valid in RUN or DONE is ignored; the operands are not sampled.
- Inputs a, b, cin and sub may change after the handshake without affecting the result.
- Partial sum bits above the current chunk are undefined during RUN. Consumers use sum only while out_valid=1.
- rst asserted mid-RUN or in DONE aborts immediately and returns to reset values; no result is produced.
- out_ready in IDLE or RUN has no effect.

Decomposition:
- Shared package (multiplier_pkg):
  - FSM state typedef {IDLE, RUN, DONE}.
  - Helper function computing NCH and CW.
  - Parameter legality check (WIDTH % CHUNK == 0) as an elaboration-time assertion.
- One sub-module, chunk_adder:
  - Purely combinational, parameter CHUNK.
  - Inputs: a, b, cin.
  - Outputs: s, cout, c_msb (carry into the top bit).
  - Built as a generate-loop ripple of full_adder instances.
- seq_chunk_adder holds the FSM, counter, operand and carry registers, and sum register.

Test Plan:
- WIDTH=32, CHUNK=8, sub=0: a=0x0000_00FF, b=0x0000_0001, cin=0 -> out_valid exactly 4 cycles after the accept edge; sum=0x0000_0100, cout=0, overflow=0 (carry crosses the chunk 0 to 1 boundary).
- Addition with signed overflow: a=0x7FFF_FFFF, b=1, cin=0 -> sum=0x8000_0000, cout=0, overflow=1.
- Addition with full wrap: a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, overflow=0.
- Subtract mode:
  - a=5, b=7, cin=0 -> sum=0xFFFF_FFFE, cout=0 (borrow), overflow=0.
  - a=0x8000_0000, b=1 -> sum=0x7FFF_FFFF, cout=1, overflow=1.
- Handshake:
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid and sum stable; in_ready=0; a second in_valid is ignored.
  - Release out_ready -> IDLE next cycle; the next op then runs correctly.
- Reset mid-RUN: assert rst two cycles after accept -> out_valid=0, sum=0, in_ready=1 immediately.
- Reset recovery: a new op after the mid-RUN reset -> correct result.
- Parameter corners:
  - CHUNK=WIDTH=16: 1-cycle latency.
  - CHUNK=1, WIDTH=8: 8-cycle latency.
  - Both configurations pass 1000 random ops against a reference model (a ± b ± cin).

Source files
------------

// File: rtl/multiplier_pkg.sv
`default_nettype none
// ============================================================================
// multiplier_pkg : shared FSM state type and chunk-count helpers
// Revision: 1.0
// ============================================================================
package multiplier_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int calc_nch(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Counter width never collapses to zero bits, even for a single chunk
   function automatic int calc_cw(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   function automatic bit params_legal(input int width, input int chunk);
      return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_chunk_adder_if.sv
`default_nettype none
// ============================================================================
// seq_chunk_adder_if : operand/result handshake bundle of seq_chunk_adder
// Revision: 1.0
// ============================================================================
interface seq_chunk_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );
endinterface
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
// chunk_adder : combinational CHUNK-bit ripple slice of full-adder cells
// Revision: 1.0
// ============================================================================
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb
);
   logic [CHUNK:0] w_c;

   assign w_c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (w_c[i]),
         .s    (s[i]),
         .cout (w_c[i+1])
      );
   end

   assign cout  = w_c[CHUNK];
   // Carry into the top bit feeds the signed-overflow detection
   assign c_msb = w_c[CHUNK-1];
endmodule
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// full_adder : single-bit full-adder cell
// Revision: 1.0
// ============================================================================
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// seq_chunk_adder : multi-cycle add/subtract, one CHUNK-bit slice per cycle
// Revision: 1.0
// ============================================================================
module seq_chunk_adder
   import multiplier_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic              clk,
   input  logic              rst,
   seq_chunk_adder_if.slave  bus
);
   localparam int            NCH      = calc_nch(WIDTH, CHUNK);
   localparam int            CW       = calc_cw(NCH);
   localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

   if (!params_legal(WIDTH, CHUNK)) begin : g_param_check
      $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
   end

   state_t           r_state;
   state_t           w_state_next;
   logic [CW-1:0]    r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;
   logic [CHUNK-1:0] w_a_chunk;
   logic [CHUNK-1:0] w_b_chunk;
   logic [CHUNK-1:0] w_s_chunk;
   logic             w_slice_cout;
   logic             w_slice_cmsb;
   logic             w_last;

   assign w_last = (r_idx == LAST_IDX);

   always_comb begin
      w_a_chunk = '0;
      w_b_chunk = '0;
      for (int k = 0; k < NCH; k++) begin
         if (r_idx == CW'(k)) begin
            w_a_chunk = r_a[k*CHUNK +: CHUNK];
            w_b_chunk = r_b[k*CHUNK +: CHUNK];
         end
      end
   end

   chunk_adder #(.CHUNK(CHUNK)) u_slice (
      .a     (w_a_chunk),
      .b     (w_b_chunk),
      .cin   (r_carry),
      .s     (w_s_chunk),
      .cout  (w_slice_cout),
      .c_msb (w_slice_cmsb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (r_state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) w_state_next = RUN;
         end
         RUN: begin
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Subtraction is folded in at accept time: A + ~B + ~cin
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.a;
                  r_b     <= bus.sub ? ~bus.b : bus.b;
                  r_carry <= bus.cin ^ bus.sub;
                  r_idx   <= '0;
               end
            end
            RUN: begin
               for (int k = 0; k < NCH; k++) begin
                  if (r_idx == CW'(k)) r_sum[k*CHUNK +: CHUNK] <= w_s_chunk;
               end
               r_carry <= w_slice_cout;
               r_idx   <= w_last ? '0 : r_idx + 1'b1;
               if (w_last) begin
                  r_cout <= w_slice_cout;
                  r_ovf  <= w_slice_cmsb ^ w_slice_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sum      = r_sum;
   assign bus.cout     = r_cout;
   assign bus.overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// tb_seq_chunk_adder : vectors, handshake corners and random ops on 3 configs
// Revision: 1.0
// ============================================================================
module tb_seq_chunk_adder;

   typedef struct {
      int          sel;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] exp_sum;
      logic        exp_cout;
      logic        exp_ovf;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        drv_in_valid;
   logic        drv_out_ready;
   logic [31:0] drv_a;
   logic [31:0] drv_b;
   logic        drv_cin;
   logic        drv_sub;
   int          sel;

   logic [31:0] res_sum;
   logic        res_cout;
   logic        res_ovf;
   logic        res_out_valid;
   logic        res_in_ready;

   int total = 0;
   int bad   = 0;
   int cfg_width [3] = '{32, 16, 8};
   int cfg_nch   [3] = '{4, 1, 8};

   seq_chunk_adder_if #(.WIDTH(32)) bus32 ();
   seq_chunk_adder_if #(.WIDTH(16)) bus16 ();
   seq_chunk_adder_if #(.WIDTH(8))  bus8  ();

   assign bus32.in_valid = drv_in_valid && (sel == 0);
   assign bus16.in_valid = drv_in_valid && (sel == 1);
   assign bus8.in_valid  = drv_in_valid && (sel == 2);
   assign bus32.a = drv_a;         assign bus32.b = drv_b;
   assign bus16.a = drv_a[15:0];   assign bus16.b = drv_b[15:0];
   assign bus8.a  = drv_a[7:0];    assign bus8.b  = drv_b[7:0];
   assign bus32.cin = drv_cin;     assign bus32.sub = drv_sub;
   assign bus16.cin = drv_cin;     assign bus16.sub = drv_sub;
   assign bus8.cin  = drv_cin;     assign bus8.sub  = drv_sub;
   assign bus32.out_ready = drv_out_ready && (sel == 0);
   assign bus16.out_ready = drv_out_ready && (sel == 1);
   assign bus8.out_ready  = drv_out_ready && (sel == 2);

   seq_chunk_adder #(.WIDTH(32), .CHUNK(8))  u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
   seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
   seq_chunk_adder #(.WIDTH(8),  .CHUNK(1))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

   always_comb begin
      res_sum       = '0;
      res_cout      = 1'b0;
      res_ovf       = 1'b0;
      res_out_valid = 1'b0;
      res_in_ready  = 1'b0;
      case (sel)
         0: begin
            res_sum = bus32.sum; res_cout = bus32.cout; res_ovf = bus32.overflow;
            res_out_valid = bus32.out_valid; res_in_ready = bus32.in_ready;
         end
         1: begin
            res_sum = {16'd0, bus16.sum}; res_cout = bus16.cout; res_ovf = bus16.overflow;
            res_out_valid = bus16.out_valid; res_in_ready = bus16.in_ready;
         end
         default: begin
            res_sum = {24'd0, bus8.sum}; res_cout = bus8.cout; res_ovf = bus8.overflow;
            res_out_valid = bus8.out_valid; res_in_ready = bus8.in_ready;
         end
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s (cfg %0d): got 0x%0h, expected 0x%0h", name, sel, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the mathematical operands
   function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub,
                                 output logic [31:0] s, output logic co, output logic ov);
      longint lim  = longint'(1) << w;
      longint mask = lim - 1;
      longint ua   = longint'(a) & mask;
      longint ub   = longint'(b) & mask;
      longint sa   = (ua >= lim / 2) ? ua - lim : ua;
      longint sb   = (ub >= lim / 2) ? ub - lim : ub;
      longint c    = longint'(cin);
      longint ures;
      longint sres;
      if (!sub) begin
         ures = ua + ub + c;
         sres = sa + sb + c;
         co   = (ures >= lim);
      end else begin
         ures = ua - ub - c;
         sres = sa - sb - c;
         co   = (ua >= ub + c);
      end
      s  = 32'(ures & mask);
      ov = (sres < -(lim / 2)) || (sres > lim / 2 - 1);
   endfunction

   task automatic start_op(input int s, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub);
      @(negedge clk);
      sel           = s;
      drv_a         = a;
      drv_b         = b;
      drv_cin       = cin;
      drv_sub       = sub;
      drv_out_ready = 1'b0;
      drv_in_valid  = 1'b1;
      #1;
      check("in_ready_idle", 32'(res_in_ready), 32'd1);
      @(posedge clk);
      #1;
      drv_in_valid = 1'b0;
      drv_a   = $urandom;
      drv_b   = $urandom;
      drv_cin = 1'($urandom);
      drv_sub = 1'($urandom);
   endtask

   task automatic wait_done();
      int lat = 0;
      while (!res_out_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(cfg_nch[sel]));
      check("in_ready_done", 32'(res_in_ready), 32'd0);
   endtask

   task automatic release_result();
      drv_out_ready = 1'b1;
      @(posedge clk);
      #1;
      drv_out_ready = 1'b0;
      check("out_valid_after_release", 32'(res_out_valid), 32'd0);
      check("in_ready_after_release", 32'(res_in_ready), 32'd1);
   endtask

   task automatic check_result(input logic [31:0] es, input logic ec, input logic eo);
      check("sum", res_sum, es);
      check("cout", 32'(res_cout), 32'(ec));
      check("overflow", 32'(res_ovf), 32'(eo));
   endtask

   task automatic random_op(input int s);
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      logic        ci = 1'($urandom);
      logic        sb = 1'($urandom);
      logic [31:0] es;
      logic        ec;
      logic        eo;
      // Bias some operands toward the edges of the signed range
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF >> (32 - cfg_width[s] + 1);
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      model(cfg_width[s], a, b, ci, sb, es, ec, eo);
      start_op(s, a, b, ci, sb);
      wait_done();
      check_result(es, ec, eo);
      release_result();
   endtask

   vec_t vecs [10];

   initial begin
      logic [31:0] es;
      logic        ec;
      logic        eo;

      vecs[0] = '{0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
      vecs[1] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[2] = '{0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[3] = '{0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[4] = '{0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[5] = '{0, 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
      vecs[6] = '{1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[7] = '{1, 32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_7FFF, 1'b1, 1'b1};
      vecs[8] = '{2, 32'h0000_007F, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0080, 1'b0, 1'b1};
      vecs[9] = '{2, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_00FF, 1'b0, 1'b0};

      rst = 1'b1;
      drv_in_valid = 1'b0; drv_out_ready = 1'b0;
      drv_a = '0; drv_b = '0; drv_cin = 1'b0; drv_sub = 1'b0; sel = 0;
      repeat (2) @(posedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check("reset_sum", res_sum, 32'd0);
         check("reset_out_valid", 32'(res_out_valid), 32'd0);
         check("reset_in_ready", 32'(res_in_ready), 32'd1);
         check("reset_cout_ovf", {30'd0, res_cout, res_ovf}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         start_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
         wait_done();
         check_result(vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
         release_result();
      end

      // Stall in DONE with a competing in_valid, then release
      model(32, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, es, ec, eo);
      start_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      wait_done();
      drv_a = 32'hDEAD_BEEF; drv_b = 32'h0BAD_F00D; drv_in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         check("stall_out_valid", 32'(res_out_valid), 32'd1);
         check("stall_in_ready", 32'(res_in_ready), 32'd0);
         check("stall_sum", res_sum, es);
      end
      drv_in_valid = 1'b0;
      release_result();
      check_result(es, ec, eo);
      random_op(0);

      // Asynchronous reset two cycles into RUN
      start_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrun_out_valid", 32'(res_out_valid), 32'd0);
      check("midrun_sum", res_sum, 32'd0);
      check("midrun_in_ready", 32'(res_in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      model(32, 32'h8765_4321, 32'h1234_5678, 1'b1, 1'b1, es, ec, eo);
      start_op(0, 32'h8765_4321, 32'h1234_5678, 1'b1, 1'b1);
      wait_done();
      check_result(es, ec, eo);
      release_result();

      for (int n = 0; n < 1000; n++) random_op(1);
      for (int n = 0; n < 1000; n++) random_op(2);
      for (int n = 0; n < 300; n++)  random_op(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
